// File: rtl/vcve2_clock_gate_ctrl.sv
// vcve2_clock_gate_ctrl
//   Sleep/wake sequencer for the core clock gate. Runs on the free-running
//   ungated clock, drains a held sleep request before dropping clk_en_o, and
//   restores the clock on interrupt, debug request or force-on. A one-cycle
//   wake_ready_o pulse marks the first RUN cycle after the settle window.
//
//   Optional feature: define VCVE2_CG_STATS_EN to add stats_clr_i and the
//   saturating gated_cycles_o counter. FSM behaviour is identical either way.
//
//   State encodings are all even parity. A single-bit upset lands on an
//   odd-parity (illegal) code, and the FSM then falls back to RUN with the
//   clock enabled.

module vcve2_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sleep_req_i,
  input  logic        wake_irq_i,
  input  logic        debug_req_i,
  input  logic        force_on_i,
`ifdef VCVE2_CG_STATS_EN
  input  logic        stats_clr_i,
  output logic [31:0] gated_cycles_o,
`endif
  output logic        clk_en_o,
  output logic        sleeping_o,
  output logic        wake_ready_o
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'b000,
    ST_DRAIN = 3'b011,
    ST_GATED = 3'b101,
    ST_WAKE  = 3'b110
  } state_e;

  // Terminal counts for the drain and settle windows.
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Even parity over the state code; every legal encoding has even parity.
  function automatic logic state_parity_ok(input logic [2:0] s);
    return ~(^s);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             sleeping_q, sleeping_d;
  logic             wake_ready_q, wake_ready_d;
  logic             wake_s;

  assign wake_s = wake_irq_i | debug_req_i | force_on_i;

  // Parameter legality checks, evaluated at elaboration.
  vcve2_clock_gate_ctrl_chk #(
    .IDLE_CYCLES (IDLE_CYCLES),
    .WAKE_CYCLES (WAKE_CYCLES),
    .CNT_W       (CNT_W)
  ) u_chk ();

  // Next-state, counter and registered-output decode for the sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wake_ready_d = 1'b0;

    if (!state_parity_ok(state_q)) begin
      state_d = ST_RUN;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (sleep_req_i && !wake_s) begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Any wake source or a dropped request aborts the drain silently.
          if (wake_s || !sleep_req_i) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == IDLE_LAST) begin
            state_d = ST_GATED;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_GATED: begin
          // sleep_req_i is meaningless here: the core clock is stopped.
          if (wake_s) begin
            state_d = ST_WAKE;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_GATED;
          end
        end
        ST_WAKE: begin
          // Inputs are ignored until the settle window completes.
          if (cnt_q == WAKE_LAST) begin
            state_d      = ST_RUN;
            cnt_d        = CNT_ZERO;
            wake_ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    clk_en_d   = (state_d != ST_GATED);
    sleeping_d = (state_d == ST_GATED);
  end

  // State, counter and output registers with synchronous reset to RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      cnt_q        <= CNT_ZERO;
      clk_en_q     <= 1'b1;
      sleeping_q   <= 1'b0;
      wake_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_en_q     <= clk_en_d;
      sleeping_q   <= sleeping_d;
      wake_ready_q <= wake_ready_d;
    end
  end

  assign clk_en_o     = clk_en_q;
  assign sleeping_o   = sleeping_q;
  assign wake_ready_o = wake_ready_q;

`ifdef VCVE2_CG_STATS_EN
  logic [31:0] gated_cnt_q, gated_cnt_d;

  // Saturating count of GATED cycles; a clear beats a same-cycle increment.
  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if (stats_clr_i) begin
      gated_cnt_d = 32'd0;
    end else if ((state_q == ST_GATED) && (gated_cnt_q != 32'hFFFF_FFFF)) begin
      gated_cnt_d = gated_cnt_q + 32'd1;
    end else begin
      gated_cnt_d = gated_cnt_q;
    end
  end

  // Gated-cycle counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gated_cnt_q <= 32'd0;
    end else begin
      gated_cnt_q <= gated_cnt_d;
    end
  end

  assign gated_cycles_o = gated_cnt_q;
`endif

endmodule

// Elaboration-time parameter checker for vcve2_clock_gate_ctrl.
module vcve2_clock_gate_ctrl_chk #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) ();

  if (IDLE_CYCLES < 1) begin : g_idle_min
    $error("vcve2_clock_gate_ctrl: IDLE_CYCLES must be >= 1");
  end

  if (WAKE_CYCLES < 1) begin : g_wake_min
    $error("vcve2_clock_gate_ctrl: WAKE_CYCLES must be >= 1");
  end

  if ($clog2(IDLE_CYCLES + 1) > CNT_W) begin : g_idle_fit
    $error("vcve2_clock_gate_ctrl: CNT_W too narrow for IDLE_CYCLES");
  end

  if ($clog2(WAKE_CYCLES + 1) > CNT_W) begin : g_wake_fit
    $error("vcve2_clock_gate_ctrl: CNT_W too narrow for WAKE_CYCLES");
  end

endmodule

// File: tb/tb_vcve2_clock_gate_ctrl.sv
// tb_vcve2_clock_gate_ctrl
//   Directed bench for vcve2_clock_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2).
//   A mode/countdown model predicts the outputs every cycle; literal checks at
//   hand-computed cycles pin the model. Define VCVE2_CG_STATS_EN to cover the
//   gated-cycle counter.

module tb_vcve2_clock_gate_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;

  localparam logic [1:0] M_RUN   = 2'd0;
  localparam logic [1:0] M_DRAIN = 2'd1;
  localparam logic [1:0] M_GATED = 2'd2;
  localparam logic [1:0] M_WAKE  = 2'd3;

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  left;
    logic        pulse;
    logic [31:0] stats;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        sleep_req_i = 1'b0;
  logic        wake_irq_i = 1'b0;
  logic        debug_req_i = 1'b0;
  logic        force_on_i = 1'b0;
  logic        stats_clr_i = 1'b0;
  logic        clk_en_o;
  logic        sleeping_o;
  logic        wake_ready_o;
`ifdef VCVE2_CG_STATS_EN
  logic [31:0] gated_cycles_o;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int base   = 0;

  mdl_t m = '0;
  logic m_valid = 1'b0;

  vcve2_clock_gate_ctrl #(
    .IDLE_CYCLES (IDLE),
    .WAKE_CYCLES (WAKE),
    .CNT_W       (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .sleep_req_i    (sleep_req_i),
    .wake_irq_i     (wake_irq_i),
    .debug_req_i    (debug_req_i),
    .force_on_i     (force_on_i),
`ifdef VCVE2_CG_STATS_EN
    .stats_clr_i    (stats_clr_i),
    .gated_cycles_o (gated_cycles_o),
`endif
    .clk_en_o       (clk_en_o),
    .sleeping_o     (sleeping_o),
    .wake_ready_o   (wake_ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc - base, act, exp);
    end
  endtask

  // Reference behaviour: a mode plus a remaining-cycles countdown.
  function automatic mdl_t model_next(input mdl_t cur, input logic rst, input logic sleep,
                                      input logic wk, input logic clr);
    mdl_t n = cur;
    n.pulse = 1'b0;
    if (rst) begin
      n.mode  = M_RUN;
      n.left  = 8'd0;
      n.stats = 32'd0;
      return n;
    end
    if (clr) n.stats = 32'd0;
    else if (cur.mode == M_GATED && cur.stats != 32'hFFFF_FFFF) n.stats = cur.stats + 32'd1;
    case (cur.mode)
      M_RUN: if (sleep && !wk) begin n.mode = M_DRAIN; n.left = 8'(IDLE); end
      M_DRAIN: begin
        if (wk || !sleep) n.mode = M_RUN;
        else begin
          n.left = cur.left - 8'd1;
          if (n.left == 8'd0) n.mode = M_GATED;
        end
      end
      M_GATED: if (wk) begin n.mode = M_WAKE; n.left = 8'(WAKE); end
      default: begin
        n.left = cur.left - 8'd1;
        if (n.left == 8'd0) begin n.mode = M_RUN; n.pulse = 1'b1; end
      end
    endcase
    return n;
  endfunction

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    m       <= model_next(m, rst_i, sleep_req_i, wake_irq_i | debug_req_i | force_on_i, stats_clr_i);
    m_valid <= m_valid | rst_i;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("mdl_clk_en", {31'd0, clk_en_o}, {31'd0, (m.mode != M_GATED)});
      check("mdl_sleeping", {31'd0, sleeping_o}, {31'd0, (m.mode == M_GATED)});
      check("mdl_wake_ready", {31'd0, wake_ready_o}, {31'd0, m.pulse});
`ifdef VCVE2_CG_STATS_EN
      check("mdl_gated_cycles", gated_cycles_o, m.stats);
`endif
    end
  end

  task automatic at_cycle(input int k);
    while (cyc < base + k) @(negedge clk);
  endtask

  // Pulse reset for one edge; cycle 0 is the first RUN cycle afterwards.
  task automatic start_test();
    sleep_req_i = 1'b0;
    wake_irq_i  = 1'b0;
    debug_req_i = 1'b0;
    force_on_i  = 1'b0;
    stats_clr_i = 1'b0;
    rst_i       = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    base  = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Gate after drain, irq wake, re-drain after wake_ready, ignored sleep drop.
    start_test();
    check("reset_clk_en", {31'd0, clk_en_o}, 32'd1);
    check("reset_sleeping", {31'd0, sleeping_o}, 32'd0);
    at_cycle(10); sleep_req_i = 1'b1;
    at_cycle(14); check("t1_drain_clk_en", {31'd0, clk_en_o}, 32'd1);
    at_cycle(15); check("t1_gated_clk_en", {31'd0, clk_en_o}, 32'd0);
                  check("t1_gated_sleeping", {31'd0, sleeping_o}, 32'd1);
    at_cycle(20); wake_irq_i = 1'b1;
    at_cycle(21); wake_irq_i = 1'b0;
                  check("t2_wake_clk_en", {31'd0, clk_en_o}, 32'd1);
                  check("t2_wake_sleeping", {31'd0, sleeping_o}, 32'd0);
                  check("t2_wr_21", {31'd0, wake_ready_o}, 32'd0);
    at_cycle(22); check("t2_wr_22", {31'd0, wake_ready_o}, 32'd0);
    at_cycle(23); check("t2_wr_23", {31'd0, wake_ready_o}, 32'd1);
    at_cycle(24); check("t2_wr_24", {31'd0, wake_ready_o}, 32'd0);
    at_cycle(28); check("t2_regated", {31'd0, clk_en_o}, 32'd0);
    at_cycle(29); sleep_req_i = 1'b0;
    at_cycle(32); check("t2_drop_ignored", {31'd0, sleeping_o}, 32'd1);
                  debug_req_i = 1'b1;
    at_cycle(33); check("t2_dbg_wake", {31'd0, clk_en_o}, 32'd1);
    at_cycle(35); check("t2_dbg_wr", {31'd0, wake_ready_o}, 32'd1);
                  debug_req_i = 1'b0;

    // Reset while gated.
    start_test();
    at_cycle(10); sleep_req_i = 1'b1;
    at_cycle(30); check("t5_pre_sleeping", {31'd0, sleeping_o}, 32'd1);
                  rst_i = 1'b1;
    at_cycle(31); rst_i = 1'b0;
                  check("t5_clk_en", {31'd0, clk_en_o}, 32'd1);
                  check("t5_sleeping", {31'd0, sleeping_o}, 32'd0);
                  check("t5_wr", {31'd0, wake_ready_o}, 32'd0);
    at_cycle(36); check("t5_regated", {31'd0, clk_en_o}, 32'd0);

    // Debug abort during drain, then a full drain once it drops.
    start_test();
    at_cycle(10); sleep_req_i = 1'b1;
    at_cycle(12); debug_req_i = 1'b1;
    for (int k = 13; k <= 20; k++) begin
      at_cycle(k);
      check("t3_clk_en", {31'd0, clk_en_o}, 32'd1);
      check("t3_no_wr", {31'd0, wake_ready_o}, 32'd0);
    end
    debug_req_i = 1'b0;
    at_cycle(24); check("t3_drain_end", {31'd0, clk_en_o}, 32'd1);
    at_cycle(25); check("t3_gated", {31'd0, clk_en_o}, 32'd0);

    // Wake on the last drain cycle beats gating.
    start_test();
    at_cycle(10); sleep_req_i = 1'b1;
    at_cycle(14); wake_irq_i = 1'b1;
    at_cycle(15); wake_irq_i = 1'b0;
                  check("tl_abort_clk_en", {31'd0, clk_en_o}, 32'd1);
    at_cycle(19); check("tl_redrain", {31'd0, clk_en_o}, 32'd1);
    at_cycle(20); check("tl_gated", {31'd0, clk_en_o}, 32'd0);

    // force_on_i held blocks gating; asserting it while gated wakes.
    start_test();
    at_cycle(10); force_on_i = 1'b1; sleep_req_i = 1'b1;
    for (int k = 10; k < 60; k++) begin
      at_cycle(k);
      check("t4_clk_en", {31'd0, clk_en_o}, 32'd1);
      check("t4_sleeping", {31'd0, sleeping_o}, 32'd0);
    end
    at_cycle(60); force_on_i = 1'b0;
    at_cycle(65); check("t4_gated", {31'd0, clk_en_o}, 32'd0);
    at_cycle(70); force_on_i = 1'b1;
    at_cycle(71); check("t4_force_wake", {31'd0, clk_en_o}, 32'd1);
    at_cycle(73); check("t4_force_wr", {31'd0, wake_ready_o}, 32'd1);
    force_on_i = 1'b0; sleep_req_i = 1'b0;

`ifdef VCVE2_CG_STATS_EN
    // Gated-cycle counter: 100 cycles, clear, clear beating increment.
    start_test();
    at_cycle(10);  sleep_req_i = 1'b1;
    at_cycle(114); wake_irq_i = 1'b1; sleep_req_i = 1'b0;
    at_cycle(115); wake_irq_i = 1'b0;
    at_cycle(116); check("t6_count_100", gated_cycles_o, 32'd100);
    at_cycle(120); stats_clr_i = 1'b1;
    at_cycle(121); stats_clr_i = 1'b0;
                   check("t6_cleared", gated_cycles_o, 32'd0);
    at_cycle(130); sleep_req_i = 1'b1;
    at_cycle(140); check("t6_count_5", gated_cycles_o, 32'd5);
                   stats_clr_i = 1'b1;
    at_cycle(141); stats_clr_i = 1'b0;
                   check("t6_clr_wins", gated_cycles_o, 32'd0);
    at_cycle(142); check("t6_resume", gated_cycles_o, 32'd1);
    sleep_req_i = 1'b0;
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
